// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master, the slave and the bench.
//   state_t        : IDLE / ACTIVE frame state of the slave
//   spi_mode_t     : {cpol, cpha} clocking mode
//   SPI_DW_DEFAULT : default word width
package spi_pkg;

  localparam int SPI_DW_DEFAULT = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-bit, multi-stage synchronizer for asynchronous inputs.
//   clk_i     : destination clock
//   rst_i     : synchronous active-high reset
//   rst_val_i : per-bit value loaded into every stage on reset
//   d_i       : asynchronous inputs
//   q_o       : synchronized outputs, Stages cycles after d_i
module spi_sync #(
  parameter int W      = 1,
  parameter int Stages = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [Stages];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Stages; i++) begin
        stage_q[i] <= rst_val_i;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder. Oversamples sclk/ss_n/mosi on clk_i, shifts a DW-bit
// word in on MOSI and out on MISO (MSB first) in all four CPOL/CPHA modes.
//   clk_i, rst_i          : system clock, synchronous active-high reset
//   cpol_i, cpha_i        : SPI mode, stable while selected
//   din_i                 : word to transmit, captured at select and after each word
//   dout_o                : last completely received word
//   spi_done_tick_o       : one-cycle pulse when dout_o updates
//   busy_o                : high while selected
//   sclk_i, ss_n_i, mosi_i: asynchronous SPI pins from the master
//   miso_o, miso_oe_o     : serial data to master and its tri-state enable
module spi_slave
  import spi_pkg::*;
#(
  parameter int DW         = SPI_DW_DEFAULT,
  parameter int SyncStages = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpol_i,
  input  logic          cpha_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          spi_done_tick_o,
  output logic          busy_o,
  input  logic          sclk_i,
  input  logic          ss_n_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe_o
);

  localparam int CW = $clog2(DW);
  localparam int FW = $clog2(SyncStages + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(SyncStages);

  spi_mode_t mode;
  assign mode = '{cpol: cpol_i, cpha: cpha_i};

  // Synchronized pins: {sclk, ss_n, mosi}
  logic [2:0] pins_w;
  logic [2:0] rst_vals_w;
  logic [2:0] synced_w;
  logic       sclk_s, ss_n_s, mosi_s;

  assign pins_w     = {sclk_i, ss_n_i, mosi_i};
  assign rst_vals_w = {cpol_i, 1'b1, 1'b0};

  spi_sync #(
    .W      (3),
    .Stages (SyncStages)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rst_val_i (rst_vals_w),
    .d_i       (pins_w),
    .q_o       (synced_w)
  );

  assign sclk_s = synced_w[2];
  assign ss_n_s = synced_w[1];
  assign mosi_s = synced_w[0];

  state_t          state_q;
  logic [DW-1:0]   tx_q;
  logic [DW-2:0]   rx_q;       // DW-1 bits of history; the current bit completes the word
  logic [CW-1:0]   bit_cnt_q;
  logic            sampled_q;
  logic            reload_q;
  logic [DW-1:0]   dout_q;
  logic            done_q;
  logic            busy_q;
  logic            sclk_prev_q;
  logic            ss_prev_q;
  // After reset the synchronizer holds fake "deselected" values. A frame may
  // start only once a genuine high ss_n has come through, so a reset while
  // ss_n is held low cannot fabricate a falling edge.
  logic [FW-1:0]   fill_q;
  logic            armed_q;

  logic [DW-1:0]   rx_d;
  logic            lead_edge, trail_edge, sample_edge, shift_edge;
  logic            ss_fall, ss_rise;

  assign rx_d        = {rx_q, mosi_s};
  assign lead_edge   = (sclk_prev_q == mode.cpol) && (sclk_s != mode.cpol);
  assign trail_edge  = (sclk_prev_q != mode.cpol) && (sclk_s == mode.cpol);
  assign sample_edge = mode.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode.cpha ? lead_edge : trail_edge;
  assign ss_fall     = armed_q && ss_prev_q && !ss_n_s;
  assign ss_rise     = ss_n_s && !ss_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      sampled_q   <= 1'b0;
      reload_q    <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sclk_prev_q <= cpol_i;
      ss_prev_q   <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_n_s;
      done_q      <= 1'b0;
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
      if (fill_q == FILL_MAX && ss_n_s) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q   <= ACTIVE;
            tx_q      <= din_i;
            bit_cnt_q <= '0;
            sampled_q <= 1'b0;
            reload_q  <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ACTIVE: begin
          // Deselect wins over any sclk edge seen in the same cycle.
          if (ss_rise) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
          end else if (sample_edge) begin
            rx_q      <= rx_d[DW-2:0];
            sampled_q <= 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              dout_q    <= rx_d;
              done_q    <= 1'b1;
              reload_q  <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (shift_edge && sampled_q) begin
            // Without a prior sample this is the cpha=1 opening edge; MSB is already out.
            if (reload_q) begin
              tx_q     <= din_i;
              reload_q <= 1'b0;
            end else begin
              tx_q <= {tx_q[DW-2:0], 1'b0};
            end
            sampled_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout_o          = dout_q;
  assign spi_done_tick_o = done_q;
  assign busy_o          = busy_q;
  assign miso_oe_o       = (state_q == ACTIVE);
  assign miso_o          = (state_q == ACTIVE) ? tx_q[DW-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives the
// pins; expected words come from what the master sent and what the host
// loaded into din_i.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int H  = SS + 3;  // sclk half period in clk cycles

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpol = 1'b0, cpha = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout_o;
  logic          spi_done_tick_o, busy_o, miso_o, miso_oe_o;
  logic          sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  logic [DW-1:0] rx_log [$];

  logic [DW-1:0] mtx [4];
  logic [DW-1:0] stx [4];
  logic [DW-1:0] mrx [4];
  int            nw;
  logic [DW-1:0] exp_dout = '0;

  spi_slave #(.DW(DW), .SyncStages(SS)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cpol_i          (cpol),
    .cpha_i          (cpha),
    .din_i           (din),
    .dout_o          (dout_o),
    .spi_done_tick_o (spi_done_tick_o),
    .busy_o          (busy_o),
    .sclk_i          (sclk),
    .ss_n_i          (ss_n),
    .mosi_i          (mosi),
    .miso_o          (miso_o),
    .miso_oe_o       (miso_oe_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi_done_tick_o) begin
      rx_log.push_back(dout_o);
      tick_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  // Half period during which the host reacts to a done tick by loading the next word.
  task automatic half_reload(input logic reload, input logic [DW-1:0] nxt);
    repeat (H) begin
      @(negedge clk);
      if (reload && spi_done_tick_o) din = nxt;
    end
  endtask

  task automatic run_frame(input int nbits);
    int t0, l0, nfull, w, i;
    logic reload;
    logic [DW-1:0] nxt;
    t0 = tick_cnt;
    l0 = rx_log.size();
    nfull = nbits / DW;
    for (int j = 0; j < 4; j++) mrx[j] = '0;
    sclk = cpol;
    mosi = 1'b0;
    half();
    din = stx[0];
    if (!cpha) mosi = mtx[0][DW-1];
    ss_n = 1'b0;
    half();
    chk("busy_sel", busy_o, 1);
    chk("oe_sel", miso_oe_o, 1);
    chk("first_bit", miso_o, stx[0][DW-1]);
    for (int k = 0; k < nbits; k++) begin
      w = k / DW;
      i = DW - 1 - (k % DW);
      reload = (i == 0) && (w + 1 < nw);
      nxt = (w < 3) ? stx[w+1] : '0;
      if (!cpha) begin
        mrx[w][i] = miso_o;
        sclk = ~cpol;
        half_reload(reload, nxt);
        sclk = cpol;
        if (k + 1 < nbits) mosi = mtx[(k+1)/DW][DW-1-((k+1)%DW)];
        half();
      end else begin
        sclk = ~cpol;
        mosi = mtx[w][i];
        half();
        mrx[w][i] = miso_o;
        sclk = cpol;
        half_reload(reload, nxt);
      end
    end
    ss_n = 1'b1;
    half();
    half();
    chk("tick_count", tick_cnt - t0, nfull);
    for (int j = 0; j < nfull; j++) begin
      chk($sformatf("slave_rx%0d", j),
          (rx_log.size() > l0 + j) ? 32'(rx_log[l0+j]) : 32'hxxxxxxxx, mtx[j]);
      chk($sformatf("master_rx%0d", j), mrx[j], stx[j]);
    end
    if (nfull > 0) exp_dout = mtx[nfull-1];
    chk("dout_hold", dout_o, exp_dout);
    chk("busy_idle", busy_o, 0);
    chk("oe_idle", miso_oe_o, 0);
    chk("miso_idle", miso_o, 0);
    $display("frame mode=%0d bits=%0d words=%0d ticks=%0d dout=%02h",
             {cpol, cpha}, nbits, nw, tick_cnt - t0, dout_o);
  endtask

  initial begin
    int m, t0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", dout_o, 0);
    chk("rst_tick", spi_done_tick_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_miso", miso_o, 0);
    chk("rst_oe", miso_oe_o, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // All four modes, A5 out of the master, 3C out of the slave
    for (int md = 0; md < 4; md++) begin
      cpol = md[1];
      cpha = md[0];
      nw = 1; mtx[0] = 8'hA5; stx[0] = 8'h3C;
      run_frame(DW);
    end

    // Two words under one select
    cpol = 1'b0; cpha = 1'b0;
    nw = 2; mtx[0] = 8'h12; mtx[1] = 8'h34; stx[0] = 8'h3C; stx[1] = 8'hC3;
    run_frame(2 * DW);

    // Abort after three bits following a completed word
    nw = 1; mtx[0] = 8'h5A; stx[0] = 8'h00;
    run_frame(DW);
    mtx[0] = 8'hFF;
    run_frame(3);
    chk("abort_dout", dout_o, 8'h5A);
    mtx[0] = 8'h81;
    run_frame(DW);

    // Reset pulse mid-word with ss_n held low
    t0 = tick_cnt;
    ss_n = 1'b0; mosi = 1'b1;
    half();
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1; half(); sclk = 1'b0; half();
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_dout", dout_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_oe", miso_oe_o, 0);
    chk("midrst_miso", miso_o, 0);
    exp_dout = '0;
    for (int k = 0; k < 8; k++) begin
      sclk = 1'b1; half(); sclk = 1'b0; half();
    end
    chk("midrst_ignored_busy", busy_o, 0);
    chk("midrst_ignored_ticks", tick_cnt - t0, 0);
    ss_n = 1'b1;
    half(); half();
    mtx[0] = 8'h6E; stx[0] = 8'h91;
    run_frame(DW);

    // Idle: sclk toggles while deselected
    t0 = tick_cnt;
    for (int k = 0; k < 10; k++) begin
      sclk = ~sclk; mosi = ~mosi;
      half();
      chk("idle_oe", miso_oe_o, 0);
      chk("idle_miso", miso_o, 0);
      chk("idle_busy", busy_o, 0);
    end
    chk("idle_ticks", tick_cnt - t0, 0);
    sclk = cpol;
    half();

    // Randomized frames
    for (int r = 0; r < 16; r++) begin
      m = $urandom_range(0, 3);
      cpol = m[1];
      cpha = m[0];
      nw = $urandom_range(1, 3);
      for (int j = 0; j < 4; j++) begin
        mtx[j] = DW'($urandom);
        stx[j] = DW'($urandom);
      end
      run_frame(nw * DW);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder: the peripheral-side counterpart of the existing `spi` master.
- Runs on the system clock `clk_i`.
- Oversamples the external `sclk_i`, `ss_n_i` and `mosi_i` lines, shifts a DW-bit word in on MOSI and a DW-bit word out on MISO in all four CPOL/CPHA modes.
- Intended to sit opposite the master in the shared `spi_if` bench, and later as a register-access front end.

Parameters:
- DW, 8, word width in bits, MSB first. Legal range 2..32.
- SyncStages, 2, synchronizer depth for `sclk_i`, `ss_n_i` and `mosi_i`. Legal minimum 2.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpol_i  in  1  SCLK idle level; must be stable while `ss_n_i` is low.
- cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge. Must be stable while `ss_n_i` is low.
- din_i  in  DW  word to transmit on MISO.
- dout_o  out  DW  last completely received MOSI word.
- spi_done_tick_o  out  1  one-cycle pulse when `dout_o` updates.
- busy_o  out  1  high while selected (synchronized `ss_n` low).
- sclk_i  in  1  SPI clock from master, asynchronous.
- ss_n_i  in  1  active-low select, asynchronous.
- mosi_i  in  1  serial data from master, asynchronous.
- miso_o  out  1  serial data to master.
- miso_oe_o  out  1  MISO output enable for an external tri-state.

Behaviour:
- Reset (`rst_i`=1 at a clk edge):
  - `dout_o`=0, `spi_done_tick_o`=0, `busy_o`=0, `miso_o`=0, `miso_oe_o`=0.
  - Shift registers and bit counter cleared; FSM to IDLE.
  - Synchronizer flops reset to inactive values: sclk=`cpol_i`, ss_n=1, mosi=0.
- Synchronization:
  - Each async input passes SyncStages flops.
  - Edges are detected by comparing the synchronized sclk with its one-cycle-delayed copy.
  - Pin-to-internal-event latency is SyncStages+1 clk cycles.
- Edge definitions:
  - Leading edge = synchronized sclk leaves the `cpol_i` level.
  - Trailing edge = synchronized sclk returns to the `cpol_i` level.
  - sample edge = leading if `cpha_i`=0, trailing if `cpha_i`=1.
  - shift edge = the other edge.
- Timing constraint: sclk high and low phases, and ss_n setup/hold to the first/last sclk edge, each ≥ SyncStages+2 clk_i cycles. Behaviour outside this is undefined.
- FSM states IDLE and ACTIVE:
  - IDLE→ACTIVE on synchronized ss_n falling: tx_reg <= din_i, bit_cnt <= 0, sampled flag <= 0, `busy_o` <= 1.
  - ACTIVE→IDLE on synchronized ss_n rising: `busy_o` <= 0, bit_cnt <= 0.
  - ACTIVE→IDLE has priority over any sclk edge detected in the same cycle.
- MISO outputs:
  - `miso_o` = tx_reg[DW-1] while ACTIVE, 0 in IDLE.
  - `miso_oe_o` = 1 exactly while ACTIVE.
  - In mode cpha=0 the first bit is valid SyncStages+1 cycles after ss_n falls, before the first sclk edge.
- On sample edge:
  - rx_reg <= {rx_reg[DW-2:0], synced mosi}; sampled flag <= 1; bit_cnt <= bit_cnt+1.
  - When bit_cnt was DW-1: bit_cnt wraps to 0, `dout_o` <= the completed word (including the current bit) in the next cycle, `spi_done_tick_o`=1 for exactly that one cycle, and the reload flag is set.
- On shift edge:
  - Ignored unless the sampled flag is 1. This makes the first leading edge in cpha=1 a no-op, since MSB is already presented.
  - If the reload flag is set: tx_reg <= din_i and the reload flag is cleared.
  - Otherwise: tx_reg <= tx_reg<<1.
  - The sampled flag is cleared after use.
- Back-to-back words: the frame continues while ss_n stays low. `din_i` is captured at ss_n assertion and at the first shift edge after each done tick. The host updates `din_i` on `spi_done_tick_o`.
- Abort: ss_n rising mid-word (bit_cnt≠0) discards the partial word. No done tick; `dout_o` keeps its old value.
- Mode inputs are not latched internally. Changing them while ACTIVE is undefined.
- `rst_i` mid-frame: immediate return to reset values, even with ss_n low. A new frame starts only after ss_n is seen high then low again.

Decomposition:
- `spi_pkg`:
  - `state_t` enum {IDLE, ACTIVE}.
  - `SPI_DW_DEFAULT`=8.
  - Mode typedef `spi_mode_t` {cpol, cpha}, shared with the master and the bench.
- Sub-module `spi_sync`: parameterized-width, SyncStages-deep synchronizer with synchronous reset and per-bit reset value. Instantiated once for {sclk, ss_n, mosi}.

Test Plan:
- Mode 0 loopback with the existing `spi` master: master din=8'hA5, slave din=8'h3C → slave `dout_o`=8'hA5 with one done pulse; master `dout_o`=8'h3C.
- Modes 1, 2, 3 with the same pair 8'hA5/8'h3C, master dvsr at the minimum meeting the timing constraint → identical results in every mode; no extra tick.
- Two words under one ss_n low: slave din changes 8'h3C→8'hC3 on the first done tick; master sends 8'h12 then 8'h34 → slave receives 8'h12 then 8'h34 (two ticks); master receives 8'h3C then 8'hC3.
- Abort: ss_n raised after 3 sclk cycles of 8'hFF following a completed 8'h5A → no tick, `dout_o` stays 8'h5A. The next full frame of 8'h81 is received correctly.
- `rst_i` pulsed mid-word with ss_n held low → all outputs 0 the next cycle, `miso_oe_o`=0. The frame is ignored until ss_n toggles high→low.
- Idle: ss_n high while sclk toggles → `miso_oe_o`=0, `miso_o`=0, `busy_o`=0, no tick.
